// File: rtl/rv32i_pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the RV32I pipeline.
// A DEPTH-entry scoreboard shift register tracks every in-flight writer from
// EX onward. From it the block derives the forward selects for each operand,
// load-use stalls for any load latency, redirect flush/kill masks, and
// saturating stall/flush counters.
module rv32i_pipe_hazard_ctrl #(
  parameter  int DEPTH       = 3,
  parameter  int LOAD_LAT    = 1,
  parameter  int REDIR_STAGE = 0,
  parameter  int CNT_W       = 16,
  localparam int SEL_W       = $clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             ID_Valid,
  input  logic [4:0]       ID_Rs1_addr,
  input  logic             ID_Rs1_used,
  input  logic [4:0]       ID_Rs2_addr,
  input  logic             ID_Rs2_used,
  input  logic [4:0]       ID_Rd_addr,
  input  logic             ID_RegFile_wr_en,
  input  logic             ID_Mem_rd_en,
  input  logic             Redirect,
  input  logic             Hold,
  output logic             Stall,
  output logic             IF_ID_Flush,
  output logic [DEPTH-1:0] Kill_mask,
  output logic [SEL_W-1:0] ForwardA,
  output logic [SEL_W-1:0] ForwardB,
  output logic [CNT_W-1:0] Stall_count,
  output logic [CNT_W-1:0] Flush_count
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wr_en;
    logic       is_load;
  } entry_t;

  // Entry 0 is the instruction in EX; higher indices are older.
  entry_t           sb_q [DEPTH];
  entry_t           sb_d [DEPTH];
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic             hit_a, rdy_a, hit_b, rdy_b;
  logic [SEL_W-1:0] idx_a, idx_b;
  logic             hazard;
  logic             redirect_go;
  logic             issue;
  logic [DEPTH-1:0] kill;

  // An entry produces a value this operand must take instead of the register file.
  function automatic logic is_match(entry_t e, logic [4:0] rs, logic used);
    return e.valid && e.wr_en && used && (rs != 5'd0) && (e.rd == rs);
  endfunction

  // Find the youngest matching entry per operand and whether its result exists yet.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    hit_a = 1'b0;
    rdy_a = 1'b0;
    idx_a = '0;
    hit_b = 1'b0;
    rdy_b = 1'b0;
    idx_b = '0;
    // Walk from oldest to youngest so the youngest match overwrites the rest.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (is_match(sb_q[i], ID_Rs1_addr, ID_Rs1_used)) begin
        hit_a = 1'b1;
        idx_a = SEL_W'(i);
        rdy_a = !sb_q[i].is_load || (i >= LOAD_LAT);
      end
      if (is_match(sb_q[i], ID_Rs2_addr, ID_Rs2_used)) begin
        hit_b = 1'b1;
        idx_b = SEL_W'(i);
        rdy_b = !sb_q[i].is_load || (i >= LOAD_LAT);
      end
    end
  end

  assign hazard      = ID_Valid && ((hit_a && !rdy_a) || (hit_b && !rdy_b));
  assign redirect_go = Redirect && !Hold;
  assign issue       = ID_Valid && !hazard && !Redirect;

  assign ForwardA    = (hit_a && rdy_a) ? idx_a + SEL_W'(1) : '0;
  assign ForwardB    = (hit_b && rdy_b) ? idx_b + SEL_W'(1) : '0;
  // A redirect discards the ID instruction, so a hazard it shadows never stalls.
  assign Stall       = Hold || (hazard && !Redirect);
  assign IF_ID_Flush = redirect_go;
  assign Kill_mask   = kill;
  assign Stall_count = stall_cnt_q;
  assign Flush_count = flush_cnt_q;

  // Entries younger than the redirecting stage are nullified.
  always_comb begin
    kill = '0;
    for (int i = 0; i < DEPTH; i++) begin
      kill[i] = redirect_go && (i < REDIR_STAGE);
    end
  end

  // Next scoreboard contents and saturating counter values.
  always_comb begin
    sb_d[0] = issue ? '{valid: 1'b1, rd: ID_Rd_addr, wr_en: ID_RegFile_wr_en,
                        is_load: ID_Mem_rd_en}
                    : '0;
    for (int i = 1; i < DEPTH; i++) begin
      sb_d[i] = sb_q[i-1];
      if (kill[i-1]) sb_d[i].valid = 1'b0;
    end
    stall_cnt_d = stall_cnt_q;
    if (hazard && !Redirect && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    flush_cnt_d = flush_cnt_q;
    if (Redirect && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // Advance the scoreboard and counters unless the pipeline is globally held.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      // NOTE: the scoreboard is reset (unlike a data RAM) because a stale valid bit would forward garbage.
      for (int i = 0; i < DEPTH; i++) sb_q[i] <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (!Hold) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      for (int i = 0; i < DEPTH; i++) sb_q[i] <= sb_d[i];
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule
